// File: rtl/seu_uart_pkg.sv
// Shared definitions for the SEU-report UART receiver: state encoding, frame
// layout (38 frame bits, guard positions, byte offsets) and small decode helpers.
package seu_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 38;

  localparam int GUARD_STOP_0  = 8;
  localparam int GUARD_STOP_1  = 18;
  localparam int GUARD_STOP_2  = 28;
  localparam int GUARD_START_0 = 9;
  localparam int GUARD_START_1 = 19;
  localparam int GUARD_START_2 = 29;

  localparam int BYTE0_OFF = 0;
  localparam int BYTE1_OFF = 10;
  localparam int BYTE2_OFF = 20;
  localparam int BYTE3_OFF = 30;

  function automatic logic [31:0] frame_to_word(input logic [FRAME_BITS-1:0] f);
    return {f[BYTE3_OFF +: 8], f[BYTE2_OFF +: 8], f[BYTE1_OFF +: 8], f[BYTE0_OFF +: 8]};
  endfunction

  function automatic logic guard_ok(input logic [FRAME_BITS-1:0] f);
    return f[GUARD_STOP_0] & f[GUARD_STOP_1] & f[GUARD_STOP_2] &
           ~f[GUARD_START_0] & ~f[GUARD_START_1] & ~f[GUARD_START_2];
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/seu_uart_rx32_if.sv
// Line and RX-FIFO side signals of the SEU-report UART receiver.
// slave = receiver side, master = environment (pin driver + FIFO).
interface seu_uart_rx32_if;
  logic        clk_en;
  logic        rxd;
  logic        rx_fifo_full;
  logic        rx_fifo_wr_en;
  logic [31:0] rx_fifo_wr_data;
  logic        rx_frame_err;
  logic        rx_overflow;
  logic        rx_busy;

  modport slave (
    input  clk_en, rxd, rx_fifo_full,
    output rx_fifo_wr_en, rx_fifo_wr_data, rx_frame_err, rx_overflow, rx_busy
  );

  modport master (
    output clk_en, rxd, rx_fifo_full,
    input  rx_fifo_wr_en, rx_fifo_wr_data, rx_frame_err, rx_overflow, rx_busy
  );
endinterface

// File: rtl/seu_uart_rx_sync.sv
// rxd metastability synchroniser (SYNC_STAGES >= 2 flops, reset to idle high)
// followed by a falling-edge detector on the synchronised value.
module seu_uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_rxd,
  output logic o_rxd_s,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rxd_s = r_sync[SYNC_STAGES-1];
  assign o_fall  = r_prev & ~r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/seu_uart_rx32.sv
// seu_uart_rx32: receives 40-bit-per-word UART frames and writes good words to the RX FIFO.
// Option macro SEU_UART_RX_MAJORITY_EN: 2-of-3 vote over the three ticks around each mid-bit.
module seu_uart_rx32
  import seu_uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 6,
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  seu_uart_rx32_if.slave bus
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(FRAME_BITS);
`ifdef SEU_UART_RX_MAJORITY_EN
  localparam int START_TICKS = OVERSAMPLE / 2 + 1;
`else
  localparam int START_TICKS = OVERSAMPLE / 2;
`endif
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TICKS - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(FRAME_BITS - 1);

  logic w_rxd_s;
  logic w_fall;
  logic w_bit;

  seu_uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_rxd   (bus.rxd),
    .o_rxd_s (w_rxd_s),
    .o_fall  (w_fall)
  );

`ifdef SEU_UART_RX_MAJORITY_EN
  // Two previous tick samples; the decision tick supplies the third vote.
  logic [1:0] r_hist;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist <= 2'b11;
    end else if (bus.clk_en) begin
      r_hist <= {r_hist[0], w_rxd_s};
    end
  end
  assign w_bit = maj3(r_hist[1], r_hist[0], w_rxd_s);
`else
  assign w_bit = w_rxd_s;
`endif

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_wr_en;
  logic [31:0]           r_wr_data;
  logic                  r_err;
  logic                  r_ovf;

  // Frame FSM; all timing is taken from the single start edge, no per-byte resync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= 32'h0000_0000;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_fall) begin
            r_state <= START;
          end
        end
        START: begin
          if (bus.clk_en) begin
            if (r_cnt == START_LAST) begin
              r_cnt   <= '0;
              r_idx   <= '0;
              r_state <= w_bit ? IDLE : DATA;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (bus.clk_en) begin
            if (r_cnt == BIT_LAST) begin
              r_cnt          <= '0;
              r_frame[r_idx] <= w_bit;
              r_idx          <= r_idx + IDX_W'(1);
              if (r_idx == LAST_IDX) begin
                r_state <= STOP;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (bus.clk_en) begin
            if (r_cnt == BIT_LAST) begin
              r_cnt   <= '0;
              r_state <= IDLE;
              if (!(guard_ok(r_frame) && w_bit)) begin
                r_err <= 1'b1;
              end else if (bus.rx_fifo_full) begin
                r_ovf <= 1'b1;
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_data <= frame_to_word(r_frame);
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.rx_fifo_wr_en   = r_wr_en;
  assign bus.rx_fifo_wr_data = r_wr_data;
  assign bus.rx_frame_err    = r_err;
  assign bus.rx_overflow     = r_ovf;
  assign bus.rx_busy         = (r_state != IDLE);
endmodule
